// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS core front end.
package mips_pkg;

    localparam int unsigned PC_W       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: enable (hold when low), synchronous clear, async active-low reset.
module if_id_reg #(
    parameter int unsigned W       = 65,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else if (en_i) begin
            data_q <= clr_i ? RST_VAL : d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register and stall/flush counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned      PC_W      = mips_pkg::PC_W,
    parameter logic [PC_W-1:0]  RESET_PC  = mips_pkg::RESET_PC[PC_W-1:0],
    parameter logic [PC_W-1:0]  NOP_INSTR = mips_pkg::NOP_INSTR[PC_W-1:0],
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             H_stall_F,
    input  logic             H_stall_D,
    input  logic             PCSrc_D,
    input  logic             Jump_D,
    input  logic [PC_W-1:0]  PCBranch_D,
    input  logic [PC_W-1:0]  PCJump_D,
    input  logic [PC_W-1:0]  instr_F,
    output logic [PC_W-1:0]  PC_F,
    output logic [PC_W-1:0]  instr_D,
    output logic [PC_W-1:0]  PCPlus4_D,
    output logic             valid_D,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [PC_W-1:0] MASK    = PC_W'(ALIGN_MASK);
    localparam int unsigned     IF_ID_W = 2 * PC_W + 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_plus4_f;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             flush;
    logic [IF_ID_W-1:0] if_id_d, if_id_q;

    assign pc_plus4_f = pc_q + PC_W'(4);
    assign flush      = (PCSrc_D | Jump_D) & ~H_stall_D;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_d = pc_q;
        if (!H_stall_F) begin
            if (Jump_D)       pc_d = PCJump_D & MASK;
            else if (PCSrc_D) pc_d = PCBranch_D & MASK;
            else              pc_d = pc_plus4_f;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (H_stall_F && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && flush_cnt_q != '1)     flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC & MASK;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign if_id_d = {instr_F, pc_plus4_f, 1'b1};

    // Holding the register (H_stall_D) takes priority over the flush clear.
    if_id_reg #(
        .W       (IF_ID_W),
        .RST_VAL ({NOP_INSTR, {PC_W{1'b0}}, 1'b0})
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (~H_stall_D),
        .clr_i (flush),
        .d_i   (if_id_d),
        .q_o   (if_id_q)
    );

    assign PC_F      = pc_q;
    assign instr_D   = if_id_q[IF_ID_W-1 -: PC_W];
    assign PCPlus4_D = if_id_q[PC_W:1];
    assign valid_D   = if_id_q[0];
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
